// File: rtl/rgb2grey_pipe.sv
// Three-stage RGB-to-grey converter (multiply, sum, scale/clip) with
// valid/ready flow control and a saturating clip counter. Define GREY_ROUND_EN
// to round half up in the final scaling instead of truncating.
module rgb2grey_pipe #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29,
  parameter int USER_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_red,
  input  logic [PIX_W-1:0]  in_green,
  input  logic [PIX_W-1:0]  in_blue,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_grey,
  output logic [USER_W-1:0] out_user,
  output logic              out_sat,
  input  logic              sat_clr,
  output logic [CNT_W-1:0]  sat_count
);

  localparam int PW = PIX_W + COEF_W;
  localparam int SW = PW + 2;
`ifdef GREY_ROUND_EN
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] HALF = RW'(1) << (COEF_W - 1);
`else
  localparam int RW = SW;
`endif

  localparam logic [PW-1:0] KR = PW'(COEF_R);
  localparam logic [PW-1:0] KG = PW'(COEF_G);
  localparam logic [PW-1:0] KB = PW'(COEF_B);

  logic              v1, v2, v3;
  logic              adv1, adv2, adv3;
  logic [PW-1:0]     pr, pg, pb;
  logic [SW-1:0]     sum;
  logic [USER_W-1:0] u1, u2;
  logic [RW-1:0]     rsum, q;
  logic              sat3;
  logic [PIX_W-1:0]  grey3;

  // Each stage may advance whenever the stage below it will make room, so
  // empty stages are filled even while the output is stalled.
  assign adv3     = !v3 || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v3;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its upstream neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      pr <= '0;
      pg <= '0;
      pb <= '0;
      u1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      pr <= PW'(in_red) * KR;
      pg <= PW'(in_green) * KG;
      pb <= PW'(in_blue) * KB;
      u1 <= in_user;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      sum <= '0;
      u2  <= '0;
    end else if (adv2) begin
      v2  <= v1;
      sum <= SW'(pr) + SW'(pg) + SW'(pb);
      u2  <= u1;
    end
  end

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise a latch is inferred.
  always_comb begin
`ifdef GREY_ROUND_EN
    rsum = RW'(sum) + HALF;
`else
    rsum = RW'(sum);
`endif
    q     = rsum >> COEF_W;
    sat3  = |q[RW-1:PIX_W];
    grey3 = sat3 ? '1 : q[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3       <= 1'b0;
      out_grey <= '0;
      out_user <= '0;
      out_sat  <= 1'b0;
    end else if (adv3) begin
      v3       <= v2;
      out_grey <= grey3;
      out_user <= u2;
      out_sat  <= sat3;
    end
  end

  // Counts clipped pixels actually delivered; sticks at all ones.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count <= '0;
    end else if (v3 && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb2grey_pipe.sv
// Bench for rgb2grey_pipe: a default-weight instance checked against a
// scoreboard, and a 128/128/128, 2-bit-counter instance for clipping.
module tb_rgb2grey_pipe;

  typedef struct packed {
    logic [7:0] grey;
    logic [1:0] user;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_sat, sat_clr;
  logic [7:0] in_red, in_green, in_blue, out_grey;
  logic [1:0] in_user, out_user;
  logic [15:0] sat_count;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat, s_sat_clr;
  logic [7:0] s_red, s_green, s_blue, s_out_grey;
  logic [1:0] s_in_user, s_out_user, s_sat_count;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rgb2grey_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_grey(out_grey), .out_user(out_user), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  rgb2grey_pipe #(.COEF_R(128), .COEF_G(128), .COEF_B(128), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_red(s_red), .in_green(s_green), .in_blue(s_blue), .in_user(s_in_user),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_grey(s_out_grey), .out_user(s_out_user), .out_sat(s_out_sat),
    .sat_clr(s_sat_clr), .sat_count(s_sat_count)
  );

  function automatic exp_t model(int r, int g, int b, logic [1:0] u, int kr, int kg, int kb);
    exp_t e;
    int   s, q;
    s = r * kr + g * kg + b * kb;
`ifdef GREY_ROUND_EN
    s = s + 128;
`endif
    q      = s >> 8;
    e.sat  = (q > 255);
    e.grey = e.sat ? 8'hff : q[7:0];
    e.user = u;
    return e;
  endfunction

  // One clock of the default instance: scoreboard push/pop at the negedge.
  task automatic tick(output logic acc);
    exp_t e, got;
    logic exp_rdy;
    acc = 1'b0;
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      exp_rdy = !(sb.size() == 3 && !out_ready);
      n_vec++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL in_ready: got %b expected %b (held %0d)", in_ready, exp_rdy, sb.size());
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        got = '{grey: out_grey, user: out_user, sat: out_sat};
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stale_out: unexpected pixel grey=%0d", out_grey);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL pixel: got grey=%0d user=%0d sat=%b expected grey=%0d user=%0d sat=%b",
                     got.grey, got.user, got.sat, e.grey, e.user, e.sat);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        acc = 1'b1;
        sb.push_back(model(in_red, in_green, in_blue, in_user, 77, 150, 29));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int r, int g, int b, logic [1:0] u);
    in_valid = 1'b1;
    in_red   = 8'(r);
    in_green = 8'(g);
    in_blue  = 8'(b);
    in_user  = u;
  endtask

  task automatic drain(int budget);
    logic acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) tick(acc);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pixels never delivered", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic acc;
    rst = 1'b1;
    tick(acc);
    tick(acc);
    rst = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, out_grey, out_user, out_sat, sat_count} !== {1'b0, 1'b1, 8'd0, 2'd0, 1'b0, 16'd0}) begin
      n_err++;
      $display("FAIL reset: valid=%b ready=%b grey=%0d user=%0d sat=%b cnt=%0d expected 0 1 0 0 0 0",
               out_valid, in_ready, out_grey, out_user, out_sat, sat_count);
    end
    n_vec++;
    if ({s_out_valid, s_in_ready, s_sat_count} !== {1'b0, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL reset_sat: valid=%b ready=%b cnt=%0d expected 0 1 0", s_out_valid, s_in_ready, s_sat_count);
    end
  endtask

  task automatic test_latency();
    logic acc;
    out_ready = 1'b1;
    drive(255, 255, 255, 2'd1);
    tick(acc);
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_vec++;
      if (out_valid !== (c == 3)) begin
        n_err++;
        $display("FAIL latency: cycle %0d out_valid=%b expected %b", c, out_valid, (c == 3));
      end
      if (c == 3) begin
        n_vec++;
        if (out_grey !== 8'd255 || out_sat !== 1'b0) begin
          n_err++;
          $display("FAIL white: grey=%0d sat=%b expected 255 0", out_grey, out_sat);
        end
      end
      tick(acc);
    end
  endtask

  task automatic test_red();
    logic acc;
    logic [7:0] want;
`ifdef GREY_ROUND_EN
    want = 8'd77;
`else
    want = 8'd76;
`endif
    out_ready = 1'b1;
    drive(255, 0, 0, 2'd2);
    tick(acc);
    in_valid = 1'b0;
    for (int i = 0; i < 6 && sb.size() != 0; i++) begin
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out_grey !== want) begin
          n_err++;
          $display("FAIL red: grey=%0d expected %0d", out_grey, want);
        end
      end
      tick(acc);
    end
    drain(5);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   sent = 0;
    int   cyc = 0;
    while (sent < 10 && cyc < 300) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 2'($urandom_range(0, 3)));
      out_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) sent++;
      cyc++;
    end
    n_vec++;
    if (sent != 10) begin
      n_err++;
      $display("FAIL stream_accept: accepted %0d expected 10", sent);
    end
    drain(60);
  endtask

  // Sends one pixel into the clipping instance and waits for its delivery;
  // clr raises sat_clr during the output transfer cycle.
  task automatic s_send(int r, int g, int b, logic clr, output logic [7:0] grey, output logic sat);
    logic seen = 1'b0;
    grey = 8'hxx;
    sat  = 1'bx;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_red   = 8'(r);
    s_green = 8'(g);
    s_blue  = 8'(b);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_out_valid === 1'b1) begin
        seen = 1'b1;
        grey = s_out_grey;
        sat  = s_out_sat;
        s_sat_clr = clr;
      end
      @(posedge clk);
      #1;
      s_sat_clr = 1'b0;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL sat_timeout: no output within 10 cycles");
    end
  endtask

  task automatic test_saturation();
    logic [7:0] g;
    logic       s;
    s_send(255, 255, 255, 1'b0, g, s);
    n_vec++;
    if (g !== 8'd255 || s !== 1'b1 || s_sat_count !== 2'd1) begin
      n_err++;
      $display("FAIL clip: grey=%0d sat=%b cnt=%0d expected 255 1 1", g, s, s_sat_count);
    end
  endtask

  task automatic test_sat_counter();
    logic [7:0] g;
    logic       s;
    for (int k = 2; k <= 5; k++) begin
      s_send(255, 255, 255, 1'b0, g, s);
      n_vec++;
      if (s_sat_count !== 2'((k > 3) ? 3 : k)) begin
        n_err++;
        $display("FAIL sat_count: after %0d clips cnt=%0d expected %0d", k, s_sat_count, (k > 3) ? 3 : k);
      end
    end
    s_send(100, 50, 20, 1'b0, g, s);
    n_vec++;
    if (g !== 8'd85 || s !== 1'b0 || s_sat_count !== 2'd3) begin
      n_err++;
      $display("FAIL no_clip: grey=%0d sat=%b cnt=%0d expected 85 0 3", g, s, s_sat_count);
    end
    s_send(255, 255, 255, 1'b1, g, s);
    n_vec++;
    if (s_sat_count !== 2'd0) begin
      n_err++;
      $display("FAIL sat_clr: cnt=%0d expected 0", s_sat_count);
    end
    s_send(255, 255, 255, 1'b0, g, s);
    n_vec++;
    if (s_sat_count !== 2'd1) begin
      n_err++;
      $display("FAIL recount: cnt=%0d expected 1", s_sat_count);
    end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(10 * i, 20 * i, 30 * i, 2'(i));
      tick(acc);
    end
    n_vec++;
    if (sb.size() != 3 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill: held=%0d in_ready=%b expected 3 0", sb.size(), in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, sat_count, s_sat_count} !== {1'b0, 1'b1, 16'd0, 2'd0}) begin
      n_err++;
      $display("FAIL rst_mid: valid=%b ready=%b cnt=%0d s_cnt=%0d expected 0 1 0 0",
               out_valid, in_ready, sat_count, s_sat_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick(acc);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_red = '0; in_green = '0; in_blue = '0; in_user = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    s_in_valid = 1'b0; s_red = '0; s_green = '0; s_blue = '0; s_in_user = '0;
    s_out_ready = 1'b1; s_sat_clr = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_red();
    test_back_to_back();
    test_saturation();
    test_sat_counter();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
